// File: rtl/status_flag_unit.sv
// Execute-stage ALU plus NZCV status register feeding the ID-stage condition checker.
// Optional macro STATUS_BYPASS_EN forwards same-cycle flags onto the status bus.
module status_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exe_valid,
  input  logic             s_bit,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             freeze,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       status,
  output logic             flag_upd
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]       status_q;
  logic [3:0]       new_nzcv;
  logic [WIDTH:0]   wide;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   bin_ext;
  logic [WIDTH-1:0] res;
  logic             legal;
  logic             is_add;
  logic             is_sub;
  logic             c_new;
  logic             v_new;

  // Carry-in is always the registered C so ADC/SBC never see a bypassed flag.
  assign cin_ext = {{WIDTH{1'b0}}, status_q[1]};
  assign bin_ext = {{WIDTH{1'b0}}, ~status_q[1]};

  always_comb begin
    wide   = '0;
    res    = '0;
    legal  = 1'b1;
    is_add = 1'b0;
    is_sub = 1'b0;
    case (exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD: begin
        wide   = {1'b0, val1} + {1'b0, val2};
        res    = wide[WIDTH-1:0];
        is_add = 1'b1;
      end
      CMD_ADC: begin
        wide   = {1'b0, val1} + {1'b0, val2} + cin_ext;
        res    = wide[WIDTH-1:0];
        is_add = 1'b1;
      end
      CMD_SUB: begin
        wide   = {1'b0, val1} - {1'b0, val2};
        res    = wide[WIDTH-1:0];
        is_sub = 1'b1;
      end
      CMD_SBC: begin
        wide   = {1'b0, val1} - {1'b0, val2} - bin_ext;
        res    = wide[WIDTH-1:0];
        is_sub = 1'b1;
      end
      CMD_AND: res = val1 & val2;
      CMD_ORR: res = val1 | val2;
      CMD_EOR: res = val1 ^ val2;
      default: legal = 1'b0;
    endcase
  end

  // Logical ops leave C and V at their registered values; subtract carry is NOT borrow.
  always_comb begin
    c_new = status_q[1];
    v_new = status_q[0];
    if (is_add) begin
      c_new = wide[WIDTH];
      v_new = (val1[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != val1[WIDTH-1]);
    end else if (is_sub) begin
      c_new = ~wide[WIDTH];
      v_new = (val1[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != val1[WIDTH-1]);
    end
  end

  assign new_nzcv = {res[WIDTH-1], (res == '0), c_new, v_new};
  assign alu_res  = res;
  assign flag_upd = exe_valid & s_bit & ~freeze & ~flush & legal;

  always_ff @(posedge clk) begin
    if (rst)
      status_q <= 4'b0000;
    else if (flag_upd)
      status_q <= new_nzcv;
  end

`ifdef STATUS_BYPASS_EN
  assign status = flag_upd ? new_nzcv : status_q;
`else
  assign status = status_q;
`endif

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Execute-stage flag producer for the ARM pipeline. Computes the 32-bit ALU result and the NZCV flags for data-processing commands, and holds the architectural status register. Feeds the 4-bit status bus `{N,Z,C,V}` into the ID-stage condition checker, which is the consumer of this block's output. Commits flags only for valid, S-bit instructions that are neither frozen nor flushed.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. N is bit `WIDTH-1` of the result.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `exe_valid`  in  1  EXE stage holds a real instruction.
- `s_bit`  in  1  instruction requests a flag update.
- `exe_cmd`  in  4  ALU command.
- `val1`  in  WIDTH  first operand (Rn).
- `val2`  in  WIDTH  second operand (shifter output).
- `freeze`  in  1  pipeline stall; the status register holds its value.
- `flush`  in  1  EXE instruction is squashed (branch taken).
- `alu_res`  out  WIDTH  combinational ALU result.
- `status`  out  4  `{N,Z,C,V}` to the condition checker: bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
- `flag_upd`  out  1  a flag commit occurs at the next rising edge (combinational).

## Operation
- Command decode (`res` is the result; `Cin` is the registered C):
  - `0001` MOV: `val2`
  - `1001` MVN: `~val2`
  - `0010` ADD: `val1+val2`
  - `0011` ADC: `val1+val2+Cin`
  - `0100` SUB/CMP: `val1-val2`
  - `0101` SBC: `val1-val2-(1-Cin)`
  - `0110` AND/TST
  - `0111` ORR
  - `1000` EOR
- Any other code: `alu_res = 0` and the command is flag-illegal.
- Arithmetic is computed at `WIDTH+1` bits.
- C rules:
  - ADD/ADC: C = carry out.
  - SUB/SBC: C = NOT borrow (ARM convention). `val1 >= val2` for SUB gives C = 1.
- V rules:
  - ADD/ADC: V = `(a[MSB]==b[MSB]) & (res[MSB]!=a[MSB])`.
  - SUB/SBC: V = `(a[MSB]!=b[MSB]) & (res[MSB]!=a[MSB])`.
- N = `res[MSB]`. Z = (res == 0).
- Logical ops and MOV/MVN update N and Z only; C and V keep their registered values.
- `flag_upd = exe_valid & s_bit & ~freeze & ~flush & legal(exe_cmd)`.
- On `flag_upd`, the status register loads the new NZCV at the rising edge. Otherwise it holds.
- Priority: `rst` > `flush` > `freeze` > update. `freeze` and `flush` asserted together means no update.
- The ADC/SBC carry-in always comes from the registered C, never from the bypass path.

## Timing
- `alu_res` and `flag_upd` are combinational; latency is 0 cycles.
- Status register latency is 1 cycle. An update at edge k is visible on `status` after edge k, unless bypass is enabled (see Configuration).
- Reset: status register = `4'b0000`. `flag_upd` = 0 while inputs are idle. `alu_res` follows its inputs.
- `rst` asserted mid-stream clears the status on that edge, even if `flag_upd` is high in the same cycle.
- Back-to-back S instructions: each commits on its own edge. ADC in cycle k+1 sees the C written at edge k.
- Held `freeze` for n cycles: the register is unchanged for n edges. The instruction commits on the first edge after `freeze` drops, provided `exe_valid` and `s_bit` are still high.

## Configuration
- Macro: `STATUS_BYPASS_EN`.
- Defined: `status = flag_upd ? new_nzcv : status_q`. This forwards same-cycle flags to the ID-stage condition checker, so no flag stall is needed.
- Undefined: `status = status_q` only. The hazard unit must stall a conditional instruction in ID while an S instruction is in EXE.
- The register contents are identical in both builds.

## Test plan
- Reset, then ADD S, `val1=0x7FFFFFFF`, `val2=1` -> `alu_res=0x80000000`; after the edge `status=4'b1001` (N = 1, V = 1).
- SUB S, `val1=5`, `val2=5` -> `alu_res=0`; `status=4'b0110` (Z = 1, C = 1). Next cycle ADC S, `val1=1`, `val2=1` -> `alu_res=3`, `status=4'b0000`.
- SUBS with `val1=1`, `val2=2`, giving `status=4'b1000`. Next cycle AND S, `val1=0xF0`, `val2=0x0F`: operands yield 0. Required: Z = 1, N = 0, C and V unchanged from the previous registered value.
- ADD S with `freeze=1` for 3 cycles, then released -> status is unchanged for 3 edges and updates on the 4th. The same instruction with `flush=1`, or `s_bit=0`, or illegal `exe_cmd=4'b1111` -> no update and `flag_upd=0`.
- `rst=1` while ADD S is valid -> `status=0000` after the edge.
- With `STATUS_BYPASS_EN`, SUB S `3-5` -> `status=4'b1000` in the same cycle. Without the macro -> the old value in that cycle and `1000` after the edge.
